// File: rtl/branch_update_gen.sv
// branch_update_gen: ID-stage branch resolution, one-cycle redirect, and a 4-entry PHT/BTB update FIFO
module branch_update_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  output logic        allowin_o,
  input  logic        s0_valid_i,
  input  logic        s0_is_br_i,
  input  logic [31:0] s0_pc_i,
  input  logic        s0_taken_i,
  input  logic [31:0] s0_target_i,
  input  logic        s0_pred_br_i,
  input  logic [1:0]  s0_pht_i,
  input  logic        s0_btb_hit_i,
  input  logic [31:0] s0_btb_pc_i,
  input  logic        s1_valid_i,
  input  logic        s1_is_br_i,
  input  logic [31:0] s1_pc_i,
  input  logic        s1_taken_i,
  input  logic [31:0] s1_target_i,
  input  logic        s1_pred_br_i,
  input  logic [1:0]  s1_pht_i,
  input  logic        s1_btb_hit_i,
  input  logic [31:0] s1_btb_pc_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [77:0] id_to_ibus
);
  function automatic logic mis(input logic br, input logic tk, input logic pb, input logic hit,
                               input logic [31:0] bpc, input logic [31:0] tgt);
    return br ? ((tk ^ (pb & hit)) | (tk & pb & hit & (bpc != tgt))) : (pb & hit);
  endfunction
  function automatic logic [77:0] entry(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                        input logic [1:0] pht, input logic hit, input logic [31:0] bpc);
    logic [1:0] w;
    w = tk ? (pht == 2'b11 ? pht : pht + 2'd1) : (pht == 2'b00 ? pht : pht - 2'd1);
    return {1'b1, pc[12:3], w, tk & (~hit | (bpc != tgt)), pc, tgt};
  endfunction
  logic [2:0]  count;
  logic [1:0]  wptr, rptr;
  logic [77:0] mem [4];
  logic        acc0, acc1, m0, m1, enq0, enq1, pop;
  logic [31:0] rpc0, rpc1;
  logic [77:0] e0, e1;
  assign allowin_o  = count <= 3'd2;
  assign pop        = count != 3'd0;
  assign id_to_ibus = pop ? mem[rptr] : '0;
  assign acc0 = s0_valid_i & allowin_o & ~flush_i;
  assign m0   = acc0 & mis(s0_is_br_i, s0_taken_i, s0_pred_br_i, s0_btb_hit_i, s0_btb_pc_i, s0_target_i);
  // a slot-0 mispredict squashes the younger slot entirely
  assign acc1 = s1_valid_i & allowin_o & ~flush_i & ~m0;
  assign m1   = acc1 & mis(s1_is_br_i, s1_taken_i, s1_pred_br_i, s1_btb_hit_i, s1_btb_pc_i, s1_target_i);
  assign enq0 = acc0 & s0_is_br_i;
  assign enq1 = acc1 & s1_is_br_i;
  assign rpc0 = (s0_is_br_i & s0_taken_i) ? s0_target_i : s0_pc_i + 32'd4;
  assign rpc1 = (s1_is_br_i & s1_taken_i) ? s1_target_i : s1_pc_i + 32'd4;
  assign e0 = entry(s0_pc_i, s0_taken_i, s0_target_i, s0_pht_i, s0_btb_hit_i, s0_btb_pc_i);
  assign e1 = entry(s1_pc_i, s1_taken_i, s1_target_i, s1_pht_i, s1_btb_hit_i, s1_btb_pc_i);
  always_ff @(posedge clk) begin
    if (enq0) mem[wptr] <= e0;
    if (enq1) mem[enq0 ? wptr + 2'd1 : wptr] <= e1;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count         <= '0;
      wptr          <= '0;
      rptr          <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      wptr          <= wptr + 2'(enq0) + 2'(enq1);
      rptr          <= rptr + 2'(pop);
      count         <= count + 3'(enq0) + 3'(enq1) - 3'(pop);
      redirect_o    <= m0 | m1;
      redirect_pc_o <= m0 ? rpc0 : m1 ? rpc1 : '0;
    end
  end
endmodule

// File: tb/tb_branch_update_gen.sv
// tb_branch_update_gen: directed vectors with hand-computed expectations for branch_update_gen
module tb_branch_update_gen;
  logic        clk = 0, rst_n = 1, flush_i = 0;
  logic        allowin_o, redirect_o;
  logic [31:0] redirect_pc_o;
  logic [77:0] id_to_ibus;
  logic        s0_valid_i, s0_is_br_i, s0_taken_i, s0_pred_br_i, s0_btb_hit_i;
  logic        s1_valid_i, s1_is_br_i, s1_taken_i, s1_pred_br_i, s1_btb_hit_i;
  logic [31:0] s0_pc_i, s0_target_i, s0_btb_pc_i, s1_pc_i, s1_target_i, s1_btb_pc_i;
  logic [1:0]  s0_pht_i, s1_pht_i;
  int          n_cmp = 0, n_bad = 0;
  branch_update_gen dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .allowin_o(allowin_o),
    .s0_valid_i(s0_valid_i), .s0_is_br_i(s0_is_br_i), .s0_pc_i(s0_pc_i), .s0_taken_i(s0_taken_i),
    .s0_target_i(s0_target_i), .s0_pred_br_i(s0_pred_br_i), .s0_pht_i(s0_pht_i),
    .s0_btb_hit_i(s0_btb_hit_i), .s0_btb_pc_i(s0_btb_pc_i),
    .s1_valid_i(s1_valid_i), .s1_is_br_i(s1_is_br_i), .s1_pc_i(s1_pc_i), .s1_taken_i(s1_taken_i),
    .s1_target_i(s1_target_i), .s1_pred_br_i(s1_pred_br_i), .s1_pht_i(s1_pht_i),
    .s1_btb_hit_i(s1_btb_hit_i), .s1_btb_pc_i(s1_btb_pc_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .id_to_ibus(id_to_ibus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic slot(input bit s, input logic br, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic pb, input logic [1:0] pht,
                      input logic hit, input logic [31:0] bpc);
    if (!s) begin
      s0_valid_i = 1; s0_is_br_i = br; s0_pc_i = pc; s0_taken_i = tk; s0_target_i = tgt;
      s0_pred_br_i = pb; s0_pht_i = pht; s0_btb_hit_i = hit; s0_btb_pc_i = bpc;
    end else begin
      s1_valid_i = 1; s1_is_br_i = br; s1_pc_i = pc; s1_taken_i = tk; s1_target_i = tgt;
      s1_pred_br_i = pb; s1_pht_i = pht; s1_btb_hit_i = hit; s1_btb_pc_i = bpc;
    end
  endtask
  task automatic idle;
    s0_valid_i = 0; s0_is_br_i = 0; s0_pc_i = 0; s0_taken_i = 0; s0_target_i = 0;
    s0_pred_br_i = 0; s0_pht_i = 0; s0_btb_hit_i = 0; s0_btb_pc_i = 0;
    s1_valid_i = 0; s1_is_br_i = 0; s1_pc_i = 0; s1_taken_i = 0; s1_target_i = 0;
    s1_pred_br_i = 0; s1_pht_i = 0; s1_btb_hit_i = 0; s1_btb_pc_i = 0;
  endtask
  function automatic logic [77:0] ent(input logic [31:0] pc, input logic [1:0] wd,
                                      input logic we, input logic [31:0] tgt);
    return {1'b1, pc[12:3], wd, we, pc, tgt};
  endfunction
  initial begin
    logic [77:0] q[$];
    logic [77:0] e;
    logic [31:0] pa, pb;
    logic        ok;
    int          issued;
    idle();
    tick(); tick();
    rst_n = 0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_redir", redirect_o, 0);
      chk("idle_rpc", redirect_pc_o, 0);
      chk("idle_bus", id_to_ibus, 0);
      chk("idle_allow", allowin_o, 1);
      tick();
    end
    slot(0, 1, 32'h1c000010, 1, 32'h1c000100, 0, 2'b01, 0, 32'h0);
    tick(); idle();
    chk("mis_redir", redirect_o, 1);
    chk("mis_rpc", redirect_pc_o, 32'h1c000100);
    chk("mis_bus", id_to_ibus, {1'b1, 10'h002, 2'b10, 1'b1, 32'h1c000010, 32'h1c000100});
    tick();
    chk("mis_redir_off", redirect_o, 0);
    chk("mis_bus_empty", id_to_ibus, 0);
    slot(0, 1, 32'h1c000040, 1, 32'h1c000200, 1, 2'b11, 1, 32'h1c000200);
    tick(); idle();
    chk("hit_redir", redirect_o, 0);
    chk("hit_bus", id_to_ibus, {1'b1, 10'h008, 2'b11, 1'b0, 32'h1c000040, 32'h1c000200});
    tick();
    slot(0, 1, 32'h1c000020, 0, 32'h1c000080, 1, 2'b10, 1, 32'h1c000080);
    slot(1, 1, 32'h1c000024, 1, 32'h1c000300, 0, 2'b00, 0, 32'h0);
    tick(); idle();
    chk("sq_redir", redirect_o, 1);
    chk("sq_rpc", redirect_pc_o, 32'h1c000024);
    chk("sq_bus", id_to_ibus, {1'b1, 10'h004, 2'b01, 1'b0, 32'h1c000020, 32'h1c000080});
    tick();
    chk("sq_redir_off", redirect_o, 0);
    chk("sq_bus_one", id_to_ibus, 0);
    issued = 0;
    for (int c = 0; c < 30 && (issued < 8 || q.size() != 0); c++) begin
      ok = q.size() <= 2;
      chk("str_allow", allowin_o, ok);
      chk("str_redir", redirect_o, 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("str_bus", id_to_ibus, e);
      end else chk("str_bus_empty", id_to_ibus, 0);
      if (issued < 8) begin
        pa = 32'h1c001000 + 32'(issued) * 8;
        pb = pa + 8;
        slot(0, 1, pa, 0, pa + 32'h40, 0, 2'b01, 0, 32'h0);
        slot(1, 1, pb, 0, pb + 32'h40, 0, 2'b01, 0, 32'h0);
        if (ok) begin
          q.push_back(ent(pa, 2'b00, 1'b0, pa + 32'h40));
          q.push_back(ent(pb, 2'b00, 1'b0, pb + 32'h40));
          issued += 2;
        end
      end else idle();
      tick();
    end
    chk("str_drained", id_to_ibus, 0);
    slot(0, 0, 32'hfffffffc, 0, 32'h0, 1, 2'b10, 1, 32'h1c000000);
    tick(); idle();
    chk("nb_redir", redirect_o, 1);
    chk("nb_rpc", redirect_pc_o, 32'h00000000);
    chk("nb_bus", id_to_ibus, 0);
    tick();
    slot(0, 1, 32'h1c000050, 1, 32'h1c000400, 0, 2'b00, 0, 32'h0);
    slot(1, 1, 32'h1c000058, 0, 32'h1c000500, 0, 2'b11, 0, 32'h0);
    tick(); idle();
    chk("rst_pre_bus", id_to_ibus, {1'b1, 10'h00a, 2'b01, 1'b1, 32'h1c000050, 32'h1c000400});
    rst_n = 1;
    tick();
    rst_n = 0;
    chk("rst_bus", id_to_ibus, 0);
    chk("rst_allow", allowin_o, 1);
    chk("rst_redir", redirect_o, 0);
    tick();
    chk("rst_bus_after", id_to_ibus, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
